// File: rtl/gpio_input_conditioner.sv
// rtl/gpio_input_conditioner.sv - per-pin sync, optional debounce (GPIO_INPUT_DEBOUNCE_EN), edge status and irq
// Conditioned pin levels feed the GPIO read path; config lives in a word-addressed register file.
module gpio_input_conditioner #(
  parameter int IOWidth    = 72,
  parameter int IoRegWidth = 24,
  parameter int BusWidth   = 32,
  parameter int CntWidth   = 4
) (
  input  logic                reg_clk,
  input  logic                reset_in,
  input  logic [IOWidth-1:0]  raw_in,
  input  logic                wr_en,
  input  logic                rd_en,
  input  logic [3:0]          reg_addr,
  input  logic [BusWidth-1:0] wdata,
  output logic [BusWidth-1:0] rdata,
  output logic [IOWidth-1:0]  filt_out,
  output logic                irq
);

  localparam int NWords   = IOWidth / IoRegWidth;
  localparam int RiseBase = NWords;
  localparam int FallBase = 2 * NWords;
  localparam int StatBase = 3 * NWords;
  localparam int CtrlBase = 4 * NWords;

  logic [IOWidth-1:0]  r_sync1, r_sync2;
  logic [IOWidth-1:0]  r_filt, r_filt_d;
  logic [IOWidth-1:0]  r_status, r_rise_en, r_fall_en;
  logic [IOWidth-1:0]  w_filt_nxt, w_set, w_clr;
  logic [NWords-1:0]   w_rise_wr, w_fall_wr;
  logic                w_ctrl_wr;
  logic [7:0]          r_prescale;
  logic                r_irq;
  logic [BusWidth-1:0] r_rdata, w_rd_data;
  logic                w_unused_wdata;

  assign w_unused_wdata = &{1'b0, wdata[BusWidth-1:IoRegWidth]};

  // Register write decode; status words produce a write-1-to-clear mask
  always_comb begin
    w_rise_wr = '0;
    w_fall_wr = '0;
    w_clr     = '0;
    for (int i = 0; i < NWords; i++) begin
      w_rise_wr[i] = wr_en && (reg_addr == 4'(RiseBase + i));
      w_fall_wr[i] = wr_en && (reg_addr == 4'(FallBase + i));
      if (wr_en && (reg_addr == 4'(StatBase + i))) begin
        w_clr[i*IoRegWidth +: IoRegWidth] = wdata[IoRegWidth-1:0];
      end
    end
  end

  assign w_ctrl_wr = wr_en && (reg_addr == 4'(CtrlBase));

  always_ff @(posedge reg_clk or posedge reset_in) begin
    if (reset_in) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= raw_in;
      r_sync2 <= r_sync1;
    end
  end

`ifdef GPIO_INPUT_DEBOUNCE_EN
  localparam int CmpWidth = ((CntWidth > 4) ? CntWidth : 4) + 1;

  logic [3:0]                       r_filt_len;
  logic [7:0]                       r_pre_cnt;
  logic                             w_tick;
  logic [IOWidth-1:0][CntWidth-1:0] r_cnt, w_cnt_nxt;

  assign w_tick = (r_pre_cnt == 8'd0);

  // A control write restarts the tick phase with the freshly written prescale
  always_ff @(posedge reg_clk or posedge reset_in) begin
    if (reset_in) begin
      r_pre_cnt <= 8'd0;
    end else if (w_ctrl_wr) begin
      r_pre_cnt <= wdata[7:0];
    end else if (w_tick) begin
      r_pre_cnt <= r_prescale;
    end else begin
      r_pre_cnt <= r_pre_cnt - 8'd1;
    end
  end

  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_filt_nxt = r_filt;
    for (int p = 0; p < IOWidth; p++) begin
      if (r_filt_len == 4'd0) begin
        w_filt_nxt[p] = r_sync2[p];
        w_cnt_nxt[p]  = '0;
      end else if (w_ctrl_wr || (r_sync2[p] == r_filt[p])) begin
        w_cnt_nxt[p] = '0;
      end else if (w_tick) begin
        if (CmpWidth'(r_cnt[p]) + CmpWidth'(1) >= CmpWidth'(r_filt_len)) begin
          w_filt_nxt[p] = r_sync2[p];
          w_cnt_nxt[p]  = '0;
        end else begin
          w_cnt_nxt[p] = r_cnt[p] + CntWidth'(1);
        end
      end
    end
  end

  always_ff @(posedge reg_clk or posedge reset_in) begin
    if (reset_in) begin
      r_cnt      <= '0;
      r_filt_len <= 4'd4;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_ctrl_wr) begin
        r_filt_len <= wdata[11:8];
      end
    end
  end
`else
  assign w_filt_nxt = r_sync2;
`endif

  always_ff @(posedge reg_clk or posedge reset_in) begin
    if (reset_in) begin
      r_prescale <= 8'd0;
      r_rise_en  <= '0;
      r_fall_en  <= '0;
    end else begin
      if (w_ctrl_wr) begin
        r_prescale <= wdata[7:0];
      end
      for (int i = 0; i < NWords; i++) begin
        if (w_rise_wr[i]) begin
          r_rise_en[i*IoRegWidth +: IoRegWidth] <= wdata[IoRegWidth-1:0];
        end
        if (w_fall_wr[i]) begin
          r_fall_en[i*IoRegWidth +: IoRegWidth] <= wdata[IoRegWidth-1:0];
        end
      end
    end
  end

  assign w_set = (r_filt & ~r_filt_d & r_rise_en) | (~r_filt & r_filt_d & r_fall_en);

  // New edges take priority over a simultaneous clear of the same bit
  always_ff @(posedge reg_clk or posedge reset_in) begin
    if (reset_in) begin
      r_filt   <= '0;
      r_filt_d <= '0;
      r_status <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_filt   <= w_filt_nxt;
      r_filt_d <= r_filt;
      r_status <= (r_status & ~w_clr) | w_set;
      r_irq    <= |(r_status & (r_rise_en | r_fall_en));
    end
  end

  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NWords; i++) begin
      if (reg_addr == 4'(i)) begin
        w_rd_data[IoRegWidth-1:0] = r_filt[i*IoRegWidth +: IoRegWidth];
      end
      if (reg_addr == 4'(RiseBase + i)) begin
        w_rd_data[IoRegWidth-1:0] = r_rise_en[i*IoRegWidth +: IoRegWidth];
      end
      if (reg_addr == 4'(FallBase + i)) begin
        w_rd_data[IoRegWidth-1:0] = r_fall_en[i*IoRegWidth +: IoRegWidth];
      end
      if (reg_addr == 4'(StatBase + i)) begin
        w_rd_data[IoRegWidth-1:0] = r_status[i*IoRegWidth +: IoRegWidth];
      end
    end
    if (reg_addr == 4'(CtrlBase)) begin
      w_rd_data[7:0] = r_prescale;
`ifdef GPIO_INPUT_DEBOUNCE_EN
      w_rd_data[11:8] = r_filt_len;
`endif
    end
  end

  always_ff @(posedge reg_clk or posedge reset_in) begin
    if (reset_in) begin
      r_rdata <= '0;
    end else if (rd_en) begin
      r_rdata <= w_rd_data;
    end
  end

  assign rdata    = r_rdata;
  assign filt_out = r_filt;
  assign irq      = r_irq;

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// tb/tb_gpio_input_conditioner.sv - directed and random checks of gpio_input_conditioner against a behavioural model
module tb_gpio_input_conditioner;

`ifdef GPIO_INPUT_DEBOUNCE_EN
  localparam bit          DEB      = 1'b1;
  localparam logic [31:0] RST_CTRL = 32'h0000_0400;
  localparam int          RST_LAT  = 6;
`else
  localparam bit          DEB      = 1'b0;
  localparam logic [31:0] RST_CTRL = 32'h0000_0000;
  localparam int          RST_LAT  = 3;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [71:0] raw;
  logic        wr_en, rd_en;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [71:0] filt_out;
  logic        irq;

  always #5 clk = ~clk;

  gpio_input_conditioner dut (
    .reg_clk (clk),
    .reset_in(rst),
    .raw_in  (raw),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .reg_addr(addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .filt_out(filt_out),
    .irq     (irq)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model: pin pipeline as delayed samples, debounce as tick counts
  logic [71:0] m_s1, m_s2, m_filt, m_filt_d, m_status, m_re, m_fe;
  logic        m_irq;
  logic [31:0] m_rdata;
  int          m_cnt[72];
  int          m_P, m_L, m_edge, m_origin;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input int a);
    logic [31:0] r;
    r = '0;
    if (a <= 2)                r[23:0] = m_filt[a*24 +: 24];
    else if (a <= 5)           r[23:0] = m_re[(a-3)*24 +: 24];
    else if (a <= 8)           r[23:0] = m_fe[(a-6)*24 +: 24];
    else if (a <= 11)          r[23:0] = m_status[(a-9)*24 +: 24];
    else if (a == 12 && DEB)   r = 32'((m_L << 8) | m_P);
    else if (a == 12)          r = 32'(m_P);
    return r;
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_filt = '0; m_filt_d = '0;
    m_status = '0; m_re = '0; m_fe = '0; m_irq = 1'b0; m_rdata = '0;
    m_P = 0; m_L = 4; m_origin = m_edge;
    for (int p = 0; p < 72; p++) m_cnt[p] = 0;
  endtask

  task automatic step();
    int          e, a;
    bit          tick;
    logic [71:0] nf, set_v, clr_v;
    logic        nirq;
    e    = m_edge + 1;
    a    = int'(addr);
    tick = ((e - m_origin) % (m_P + 1)) == 0;
    nf   = m_filt;
    for (int p = 0; p < 72; p++) begin
      if (!DEB || m_L == 0) begin
        nf[p] = m_s2[p];
        m_cnt[p] = 0;
      end else if (wr_en && a == 12) m_cnt[p] = 0;
      else if (m_s2[p] == m_filt[p]) m_cnt[p] = 0;
      else if (tick) begin
        m_cnt[p]++;
        if (m_cnt[p] >= m_L) begin
          nf[p] = m_s2[p];
          m_cnt[p] = 0;
        end
      end
    end
    set_v = (m_filt & ~m_filt_d & m_re) | (~m_filt & m_filt_d & m_fe);
    clr_v = '0;
    if (wr_en && a >= 9 && a <= 11) clr_v[(a-9)*24 +: 24] = wdata[23:0];
    nirq = |(m_status & (m_re | m_fe));
    if (rd_en) m_rdata = m_read(a);
    m_status = (m_status & ~clr_v) | set_v;
    if (wr_en) begin
      if (a >= 3 && a <= 5)      m_re[(a-3)*24 +: 24] = wdata[23:0];
      else if (a >= 6 && a <= 8) m_fe[(a-6)*24 +: 24] = wdata[23:0];
      else if (a == 12) begin
        m_P = int'(wdata[7:0]);
        m_L = int'(wdata[11:8]);
        m_origin = e;
      end
    end
    m_s2 = m_s1; m_s1 = raw; m_filt_d = m_filt; m_filt = nf; m_irq = nirq; m_edge = e;
    @(posedge clk);
    #1;
    chk("filt_out", filt_out, m_filt);
    chk("irq", irq, m_irq);
    chk("rdata", rdata, m_rdata);
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic do_read(input int a);
    addr = 4'(a); rd_en = 1'b1;
    step();
  endtask

  task automatic do_write(input int a, input logic [31:0] d);
    addr = 4'(a); wdata = d; wr_en = 1'b1;
    step();
  endtask

  function automatic logic [71:0] sparse72();
    return 72'({$urandom & $urandom & $urandom, $urandom & $urandom & $urandom,
                $urandom & $urandom & $urandom});
  endfunction

  initial begin
    int          n;
    bit          seen;
    int          a;
    logic [31:0] d;
    rst = 1'b1; raw = '0; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0;
    m_edge = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_irq", irq, 1'b0);
    chk("reset_filt", filt_out, 72'h0);
    rst = 1'b0;

    for (int i = 0; i <= 12; i++) begin
      do_read(i);
      chk($sformatf("reset_word%0d", i), rdata, (i == 12) ? RST_CTRL : 32'h0);
    end

`ifdef GPIO_INPUT_DEBOUNCE_EN
    do_write(12, 32'h0000_0301);
    raw[0] = 1'b1;
    n = 0;
    while (n < 20 && !filt_out[0]) begin
      step();
      n++;
    end
    chk("deb_latency_7to9", (n >= 7 && n <= 9), 1'b1);
    raw[0] = 1'b0;
    idle(12);
    raw[0] = 1'b1;
    idle(4);
    raw[0] = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      step();
      if (filt_out[0]) seen = 1'b1;
    end
    chk("deb_glitch_blocked", seen, 1'b0);
`endif

    do_write(12, 32'h0000_0000);
    idle(4);
    raw[40] = 1'b1;
    idle(2);
    chk("bypass_40_before", filt_out[40], 1'b0);
    step();
    chk("bypass_40_at3", filt_out[40], 1'b1);
    do_read(1);
    chk("bypass_word1_bit16", rdata[16], 1'b1);
    raw[40] = 1'b0;
    idle(2);
    chk("bypass_40_fall_before", filt_out[40], 1'b1);
    step();
    chk("bypass_40_fall_at3", filt_out[40], 1'b0);

    do_write(3, 32'h1);
    raw[0] = 1'b1;
    idle(5);
    chk("edge_irq_set", irq, 1'b1);
    do_read(9);
    chk("edge_status_set", rdata, 32'h1);
    do_write(9, 32'h1);
    step();
    chk("edge_irq_cleared", irq, 1'b0);
    do_read(9);
    chk("edge_status_cleared", rdata, 32'h0);
    raw[0] = 1'b0;
    idle(5);
    do_read(9);
    chk("fall_disabled_status", rdata, 32'h0);
    chk("fall_disabled_irq", irq, 1'b0);

    raw[0] = 1'b1;
    idle(5);
    raw[0] = 1'b0;
    idle(5);
    raw[0] = 1'b1;
    idle(3);
    do_write(9, 32'h1);
    do_read(9);
    chk("set_beats_clear", rdata[0], 1'b1);

    do_write(12, DEB ? 32'h0000_0201 : 32'h0000_0001);
    for (int i = 0; i < 800; i++) begin
      raw = raw ^ sparse72();
      case ($urandom_range(0, 7))
        0, 1: begin
          addr = 4'($urandom_range(0, 15));
          rd_en = 1'b1;
        end
        2: begin
          a = $urandom_range(0, 15);
          d = $urandom;
          if (a == 12) d = d & 32'h0000_0303;
          addr = 4'(a); wdata = d; wr_en = 1'b1;
          if ($urandom_range(0, 1) == 1) rd_en = 1'b1;
        end
        default: ;
      endcase
      step();
    end

    do_write(12, 32'h0000_0301);
    do_write(5, 32'h00ff_ffff);
    raw = '0;
    idle(20);
    raw[71:48] = '1;
    idle(20);
    chk("pre_reset_irq", irq, 1'b1);
    raw[0] = 1'b1;
    idle(6);
    #3;
    rst = 1'b1;
    #1;
    chk("async_reset_filt", filt_out, 72'h0);
    chk("async_reset_irq", irq, 1'b0);
    model_reset();
    #1;
    rst = 1'b0;
    idle(RST_LAT - 1);
    chk("restart_pin0_early", filt_out[0], 1'b0);
    step();
    chk("restart_pin0_pass", filt_out[0], 1'b1);
    do_read(12);
    chk("restart_ctrl_default", rdata, RST_CTRL);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpio_input_conditioner.md
# gpio_input_conditioner

Per-pin input conditioner between the bidirectional GPIO pad block's raw read-back and the GPIO register decoder's 0x1000–0x1008 read path. Synchronises each raw pin to `reg_clk`, optionally debounces it with a prescaled stability filter, and captures rising/falling edges into sticky write-1-to-clear status with a masked level interrupt. Conditioned data replaces raw `data_from_gpio` as the decoder's GPIO read source. Configuration sits in a small word-addressed register file.

## Interface
Parameters:
- `IOWidth`, 72, total conditioned pins (two 36-bit GPIO headers)
- `IoRegWidth`, 24, pins per register word; `IOWidth` is a multiple of it
- `BusWidth`, 32, register data width
- `CntWidth`, 4, debounce counter width per pin

Ports:
- `reg_clk`  in  1  sole clock
- `reset_in`  in  1  asynchronous, active-high reset
- `raw_in`  in  IOWidth  unsynchronised pin data from the pad block
- `wr_en`  in  1  single-cycle register write strobe
- `rd_en`  in  1  single-cycle register read strobe
- `reg_addr`  in  4  word index
- `wdata`  in  BusWidth  write data
- `rdata`  out  BusWidth  registered read data
- `filt_out`  out  IOWidth  conditioned pin levels
- `irq`  out  1  registered OR of (status & enable)

## Operation
- Word map (N = IOWidth/IoRegWidth = 3):
  - 0–2: filtered data, read-only
  - 3–5: rise_en
  - 6–8: fall_en
  - 9–11: edge status, write-1-to-clear
  - 12: control; [7:0] prescale, [11:8] filt_len
  - 13–15: read 0, writes ignored
- Upper register bits beyond `IoRegWidth` read 0.
- Sync: two-flop chain per pin, yielding `s`.
- Prescaler:
  - 8-bit down-counter reloads `prescale`.
  - `tick` asserts for one cycle when the counter is 0, i.e. every prescale+1 cycles.
- Debounce, per pin:
  - When `s == filt`: counter := 0.
  - On `tick` with `s != filt`: counter += 1.
  - When counter reaches `filt_len`: filt := s and counter := 0.
  - filt_len = 0: filt := s every cycle, no tick dependency.
  - Counter never wraps; filt_len ≤ 15.
- Edge capture:
  - rise = filt & ~filt_d; fall = ~filt & filt_d.
  - status |= (rise & rise_en) | (fall & fall_en).
  - A W1C write clears the written 1-bits.
  - If set and clear hit the same bit in the same cycle, set wins.
- `irq` <= |(status & (rise_en | fall_en)).
- Simultaneous `wr_en` and `rd_en`: both execute; the read returns the pre-write value.
- Writing control reloads the prescaler immediately and zeroes all debounce counters.

## Timing
- Reset values:
  - filt, filt_d, sync flops, counters: 0
  - status, rise_en, fall_en: 0
  - prescale = 0, filt_len = 4
  - `rdata`, `irq`: 0
- `rdata` is valid the cycle after `rd_en` and holds until the next read.
- Write takes effect the cycle after `wr_en`.
- Raw-to-filt latency:
  - filt_len = 0: 3 cycles.
  - Otherwise: 2 sync cycles plus filt_len ticks, where the counter reaches filt_len.
- Status sets 1 cycle after the filt change; `irq` follows 1 cycle later.
- Reset asserted mid-filter aborts it immediately; all state returns to reset values asynchronously.

## Configuration
- `GPIO_INPUT_DEBOUNCE_EN` defined:
  - Prescaler, counters and filt_len are implemented as above.
- Not defined:
  - filt = s every cycle (3-cycle latency).
  - Control word [11:8] reads 0; prescale still reads back but has no effect.
  - Edge capture, irq and the register map are unchanged.

## Test plan
- Reset defaults:
  - Release reset, read words 0–12 → all 0 except word 12 = 0x00000400.
  - `irq` = 0.
- Debounce:
  - prescale = 1, filt_len = 3; raise raw_in[0] and hold.
  - filt_out[0] rises 2 + (3 ticks × 2 cycles) cycles later, ±1 for tick phase.
  - A 4-cycle glitch never reaches filt_out.
- Bypass:
  - filt_len = 0; toggle raw_in[40] → filt_out[40] follows exactly 3 cycles later.
  - Word 1 bit 16 matches filt_out[40].
- Edge/irq:
  - rise_en word 3 = 0x1; pulse raw_in[0] high.
  - Status word 9 = 0x1 and `irq` = 1.
  - Write 0x1 to word 9 → status 0 and `irq` = 0 one cycle later.
  - fall_en = 0 means the falling edge sets no status.
- Set-vs-clear:
  - W1C of bit 0 in the same cycle as a new enabled rising edge on pin 0 → status bit stays 1.
- Mid-operation reset:
  - Assert `reset_in` while a counter is at 2 → after release, counters 0, filt_out = 0, `irq` = 0.
  - Filter restarts from zero.
